div_ctrl: RTL and testbench

//  Divide-sequencing stage between the EX-stage M-extension decode and the unsigned divider core.
//  - Accepts DIV/DIVU/REM/REMU requests.
//  - Resolves divide-by-zero and signed overflow locally.
//  - Converts signed operands to magnitudes and drives the divider with a held start/done handshake.
//  - Sign-corrects the quotient/remainder and returns one registered write-back result.

---
 rtl/div_ctrl_if.sv | 24 ++
 rtl/div_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_div_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_if.sv
// Request/response bundle between the EX-stage M decode and div_ctrl.
// master drives requests; slave is the divide sequencer.
interface div_ctrl_if #(
  parameter int DW = 32
);
  logic          div_req;
  logic [1:0]    div_op;
  logic [DW-1:0] div_src1;
  logic [DW-1:0] div_src2;
  logic          div_flush;
  logic          div_busy;
  logic          div_rdy;
  logic [DW-1:0] div_wb_data;

  modport master (
    output div_req, div_op, div_src1, div_src2, div_flush,
    input  div_busy, div_rdy, div_wb_data
  );

  modport slave (
    input  div_req, div_op, div_src1, div_src2, div_flush,
    output div_busy, div_rdy, div_wb_data
  );
endinterface

// File: rtl/div_ctrl.sv
// Divide sequencer: special cases, sign handling, unsigned core handshake.
// Optional result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_ctrl #(
  parameter int DW = 32
) (
  input  logic          cpu_clk,
  input  logic          cpu_rstn,
  div_ctrl_if.slave     bus,
  output logic          u_start,
  input  logic          u_done,
  output logic [DW-1:0] u_src1,
  output logic [DW-1:0] u_src2,
  input  logic [DW-1:0] u_quo,
  input  logic [DW-1:0] u_rem
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [1:0]    r_op;
  logic          r_sign1;
  logic          r_sign2;
  logic [DW-1:0] r_usrc1;
  logic [DW-1:0] r_usrc2;
  logic [DW-1:0] r_quo;
  logic [DW-1:0] r_rem;
  logic [DW-1:0] r_wb;

  logic          w_signed;
  logic          w_neg1;
  logic          w_neg2;
  logic [DW-1:0] w_mag1;
  logic [DW-1:0] w_mag2;
  logic          w_zero;
  logic          w_ovf;
  logic          w_special;
  logic [DW-1:0] w_spec_val;
  logic          w_acc;
  logic          w_cap;
  logic          w_hit;
  logic [DW-1:0] w_c_quo;
  logic [DW-1:0] w_c_rem;
  logic [DW-1:0] w_fix;
  logic [DW-1:0] w_min;

  assign w_min    = {1'b1, {(DW-1){1'b0}}};
  assign w_signed = ~bus.div_op[0];
  assign w_neg1   = w_signed & bus.div_src1[DW-1];
  assign w_neg2   = w_signed & bus.div_src2[DW-1];
  assign w_mag1   = w_neg1 ? (~bus.div_src1 + 1'b1)
                           : bus.div_src1;
  assign w_mag2   = w_neg2 ? (~bus.div_src2 + 1'b1)
                           : bus.div_src2;

  assign w_zero    = (bus.div_src2 == '0);
  assign w_ovf     = w_signed
                   & (bus.div_src1 == w_min)
                   & (bus.div_src2 == '1);
  assign w_special = w_zero | w_ovf;

  assign w_acc = (r_state == S_IDLE)
               & bus.div_req & ~bus.div_flush;
  assign w_cap = (r_state == S_RUN)
               & u_done & ~bus.div_flush;

  always_comb begin
    w_spec_val = '0;
    unique case (1'b1)
      w_zero:
        w_spec_val = bus.div_op[1] ? bus.div_src1 : '1;
      default:
        w_spec_val = bus.div_op[1] ? '0 : bus.div_src1;
    endcase
  end

  always_comb begin
    w_fix = '0;
    unique case (1'b1)
      r_op[1]:
        w_fix = r_sign1 ? (~r_rem + 1'b1) : r_rem;
      default:
        w_fix = ((r_op == 2'b00) && (r_sign1 ^ r_sign2))
              ? (~r_quo + 1'b1) : r_quo;
    endcase
  end

`ifdef DIV_RESULT_CACHE_EN
  logic          r_c_vld;
  logic          r_c_sgn;
  logic [DW-1:0] r_c_src1;
  logic [DW-1:0] r_c_src2;
  logic [DW-1:0] r_c_quo;
  logic [DW-1:0] r_c_rem;
  logic [DW-1:0] r_raw1;
  logic [DW-1:0] r_raw2;

  // Keyed on raw operands, so a sign flip on either input misses.
  assign w_hit = r_c_vld
               & (r_c_sgn == w_signed)
               & (r_c_src1 == bus.div_src1)
               & (r_c_src2 == bus.div_src2);
  assign w_c_quo = r_c_quo;
  assign w_c_rem = r_c_rem;

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_c_vld  <= 1'b0;
      r_c_sgn  <= 1'b0;
      r_c_src1 <= '0;
      r_c_src2 <= '0;
      r_c_quo  <= '0;
      r_c_rem  <= '0;
      r_raw1   <= '0;
      r_raw2   <= '0;
    end else begin
      if (w_acc) begin
        r_raw1 <= bus.div_src1;
        r_raw2 <= bus.div_src2;
      end
      if (w_cap) begin
        r_c_vld  <= 1'b1;
        r_c_sgn  <= ~r_op[0];
        r_c_src1 <= r_raw1;
        r_c_src2 <= r_raw2;
        r_c_quo  <= u_quo;
        r_c_rem  <= u_rem;
      end
    end
  end
`else
  assign w_hit   = 1'b0;
  assign w_c_quo = '0;
  assign w_c_rem = '0;
`endif

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn)
      r_state <= S_IDLE;
    else
      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_acc)
          w_nxt = w_special ? S_RESP
                : (w_hit ? S_FIX : S_RUN);
      S_RUN:
        if (u_done)
          w_nxt = S_FIX;
      S_FIX:
        w_nxt = S_RESP;
      S_RESP:
        w_nxt = S_IDLE;
      default:
        w_nxt = S_IDLE;
    endcase
    // Kill wins over every other transition, including u_done.
    if (bus.div_flush)
      w_nxt = S_IDLE;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_op    <= '0;
      r_sign1 <= 1'b0;
      r_sign2 <= 1'b0;
      r_usrc1 <= '0;
      r_usrc2 <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_wb    <= '0;
    end else begin
      if (w_acc) begin
        r_op    <= bus.div_op;
        r_sign1 <= w_neg1;
        r_sign2 <= w_neg2;
        r_usrc1 <= w_mag1;
        r_usrc2 <= w_mag2;
        if (w_special)
          r_wb <= w_spec_val;
        if (w_hit) begin
          r_quo <= w_c_quo;
          r_rem <= w_c_rem;
        end
      end
      if (w_cap) begin
        r_quo <= u_quo;
        r_rem <= u_rem;
      end
      if ((r_state == S_FIX) && !bus.div_flush)
        r_wb <= w_fix;
    end
  end

  assign u_start         = (r_state == S_RUN);
  assign u_src1          = r_usrc1;
  assign u_src2          = r_usrc2;
  assign bus.div_busy    = (r_state != S_IDLE);
  assign bus.div_rdy     = (r_state == S_RESP)
                         & ~bus.div_flush;
  assign bus.div_wb_data = r_wb;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: vector table, flush/reset sequences, random ops.
// Reference results come from plain signed/unsigned arithmetic.
module tb_div_ctrl;
  localparam int DW = 32;

  logic cpu_clk = 1'b0;
  logic cpu_rstn = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  div_ctrl_if #(.DW(DW)) bus ();

  logic          u_start;
  logic          u_done;
  logic [DW-1:0] u_src1;
  logic [DW-1:0] u_src2;
  logic [DW-1:0] u_quo;
  logic [DW-1:0] u_rem;

  div_ctrl #(.DW(DW)) dut (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .bus      (bus),
    .u_start  (u_start),
    .u_done   (u_done),
    .u_src1   (u_src1),
    .u_src2   (u_src2),
    .u_quo    (u_quo),
    .u_rem    (u_rem)
  );

  // Unsigned core: done after core_delay extra cycles of u_start.
  int core_delay = 0;
  int core_cnt;
  always @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn)
      core_cnt <= 0;
    else if (u_start && !u_done)
      core_cnt <= core_cnt + 1;
    else
      core_cnt <= 0;
  end
  assign u_done = u_start && (core_cnt >= core_delay);
  assign u_quo  = (u_src2 == '0) ? '1 : u_src1 / u_src2;
  assign u_rem  = (u_src2 == '0) ? u_src1 : u_src1 % u_src2;

  int start_cyc = 0;
  int rdy_cnt = 0;
  always @(negedge cpu_clk) begin
    if (u_start) start_cyc = start_cyc + 1;
    if (bus.div_rdy) rdy_cnt = rdy_cnt + 1;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] ref_res(
    input logic [1:0] op,
    input logic [31:0] a,
    input logic [31:0] b);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    bit ovf;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'd0: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return 32'(sa / sb);
      end
      2'd1: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return 32'(ua / ub);
      end
      2'd2: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return 32'(ua % ub);
      end
    endcase
  endfunction

  bit          mc_vld = 1'b0;
  bit          mc_sg;
  logic [31:0] mc_a;
  logic [31:0] mc_b;

  // Expected accept-to-rdy latency; also tracks the result cache.
  task automatic model_lat(input logic [1:0] op,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           output int lat);
    bit sg;
    bit sp;
    sg = ~op[0];
    sp = (b == 0) ||
         (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    if (sp)
      lat = 1;
`ifdef DIV_RESULT_CACHE_EN
    else if (mc_vld && mc_a == a && mc_b == b && mc_sg == sg)
      lat = 2;
`endif
    else begin
      lat = 3 + core_delay;
      mc_vld = 1'b1;
      mc_sg = sg;
      mc_a = a;
      mc_b = b;
    end
  endtask

  task automatic do_op(input string nm,
                       input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] exp,
                       input bit noise);
    int el;
    int lat;
    int s0;
    int s1;
    bit seen;
    model_lat(op, a, b, el);
    bus.div_req = 1'b1;
    bus.div_op = op;
    bus.div_src1 = a;
    bus.div_src2 = b;
    @(posedge cpu_clk);
    s0 = start_cyc;
    seen = 1'b0;
    lat = 0;
    for (int k = 1; k <= 80 && !seen; k++) begin
      @(negedge cpu_clk);
      if (bus.div_rdy) begin
        seen = 1'b1;
        lat = k;
        bus.div_req = 1'b0;
      end else if (noise) begin
        bus.div_req = 1'b1;
        bus.div_op = 2'($urandom);
        bus.div_src1 = $urandom;
        bus.div_src2 = $urandom;
      end else begin
        bus.div_req = 1'b0;
      end
    end
    bus.div_req = 1'b0;
    if (!seen)
      chk({nm, " timeout"}, 32'd0, 32'd1);
    chk({nm, " data"}, bus.div_wb_data, exp);
    chk({nm, " latency"}, lat, el);
    @(posedge cpu_clk);
    s1 = start_cyc;
    chk({nm, " u_start cycles"}, s1 - s0,
        (el >= 3) ? el - 2 : 0);
    @(negedge cpu_clk);
    chk({nm, " rdy pulse"}, {31'd0, bus.div_rdy}, 32'd0);
    chk({nm, " idle"}, {31'd0, bus.div_busy}, 32'd0);
    chk({nm, " held"}, bus.div_wb_data, exp);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[16];
  logic [31:0] last_wb;
  int r0;

  task automatic long_op_then_stop(input bit use_rst);
    core_delay = 33;
    bus.div_req = 1'b1;
    bus.div_op = 2'd1;
    bus.div_src1 = 32'd100;
    bus.div_src2 = 32'd7;
    @(posedge cpu_clk);
    r0 = rdy_cnt;
    @(negedge cpu_clk);
    bus.div_req = 1'b0;
    repeat (9) @(negedge cpu_clk);
    chk("long op busy", {31'd0, bus.div_busy}, 32'd1);
    if (use_rst) begin
      cpu_rstn = 1'b0;
      #1;
      mc_vld = 1'b0;
      last_wb = '0;
      chk("rst busy", {31'd0, bus.div_busy}, 32'd0);
      chk("rst u_start", {31'd0, u_start}, 32'd0);
      chk("rst rdy", {31'd0, bus.div_rdy}, 32'd0);
      chk("rst wb", bus.div_wb_data, 32'd0);
      @(negedge cpu_clk);
      cpu_rstn = 1'b1;
    end else begin
      bus.div_flush = 1'b1;
      @(posedge cpu_clk);
      #1;
      bus.div_flush = 1'b0;
      chk("flush busy", {31'd0, bus.div_busy}, 32'd0);
      chk("flush u_start", {31'd0, u_start}, 32'd0);
    end
    repeat (40) @(negedge cpu_clk);
    @(posedge cpu_clk);
    #1;
    chk("stop no rdy", rdy_cnt - r0, 32'd0);
    chk("stop wb kept", bus.div_wb_data, last_wb);
    core_delay = 0;
    @(negedge cpu_clk);
    do_op("after stop divu 9/3", 2'd1, 32'd9, 32'd3, 32'd3, 1'b0);
    last_wb = 32'd3;
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pa;
    logic [31:0] pb;
    int sel;

    bus.div_req = 1'b0;
    bus.div_op = 2'd0;
    bus.div_src1 = '0;
    bus.div_src2 = '0;
    bus.div_flush = 1'b0;
    repeat (3) @(negedge cpu_clk);
    chk("reset busy", {31'd0, bus.div_busy}, 32'd0);
    chk("reset rdy", {31'd0, bus.div_rdy}, 32'd0);
    chk("reset u_start", {31'd0, u_start}, 32'd0);
    chk("reset wb", bus.div_wb_data, 32'd0);
    chk("reset u_src1", u_src1, 32'd0);
    chk("reset u_src2", u_src2, 32'd0);
    cpu_rstn = 1'b1;
    @(negedge cpu_clk);

    tbl[0]  = '{2'd1, 32'd100, 32'd7, 32'd14};
    tbl[1]  = '{2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
    tbl[2]  = '{2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
    tbl[3]  = '{2'd3, 32'hFFFF_FFF9, 32'd2, 32'd1};
    tbl[4]  = '{2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF};
    tbl[5]  = '{2'd3, 32'd5, 32'd0, 32'd5};
    tbl[6]  = '{2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    tbl[7]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    tbl[8]  = '{2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    tbl[9]  = '{2'd0, 32'd100, 32'd7, 32'd14};
    tbl[10] = '{2'd2, 32'd100, 32'd7, 32'd2};
    tbl[11] = '{2'd1, 32'd100, 32'd7, 32'd14};
    tbl[12] = '{2'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3};
    tbl[13] = '{2'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    tbl[14] = '{2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1};
    tbl[15] = '{2'd0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD};

    for (int i = 0; i < 16; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].op,
            tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0);
      last_wb = tbl[i].exp;
    end

    // Flush coincident with a request in IDLE drops the request.
    bus.div_req = 1'b1;
    bus.div_flush = 1'b1;
    bus.div_op = 2'd0;
    bus.div_src1 = 32'd5;
    bus.div_src2 = 32'd0;
    @(posedge cpu_clk);
    #1;
    bus.div_req = 1'b0;
    bus.div_flush = 1'b0;
    chk("flush+req busy", {31'd0, bus.div_busy}, 32'd0);
    @(negedge cpu_clk);
    chk("flush+req wb", bus.div_wb_data, last_wb);

    long_op_then_stop(1'b0);
    long_op_then_stop(1'b1);

    pa = 32'd100;
    pb = 32'd7;
    for (int i = 0; i < 150; i++) begin
      core_delay = $urandom_range(0, 2);
      op = 2'($urandom);
      sel = $urandom_range(0, 7);
      case (sel)
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = pa; b = pb; end
        3: begin a = $urandom; b = $urandom_range(1, 15); end
        4: begin a = $urandom; b = -$urandom_range(1, 15); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      do_op($sformatf("rand%0d", i), op, a, b,
            ref_res(op, a, b), 1'($urandom));
      pa = a;
      pb = b;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
